frame_sequencer: RTL and testbench

- Per-frame controller between the VGA timing generator, the gpu rasterizer and a double-buffered framebuffer RAM.
- At each frame start it clears the back buffer to a background colour, pulses gpu start, then owns the framebuffer write port on the gpu's behalf until gpu done.
- At the next vsync it swaps the display and back banks.
- The gpu and the command FIFO are unchanged; this block replaces the testbench-driven start pulse.

---
 rtl/frame_sequencer.sv | 137 +++++++++++++
 tb/tb_frame_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame clear / render / swap controller that sits
// between the VGA timing, the gpu rasterizer and a double-buffered framebuffer.
module frame_sequencer #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int ADDR_W  = 19,
    parameter int COLOR_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               vsync,
    input  logic [COLOR_W-1:0] bg_color,
    output logic               gpu_start,
    input  logic               gpu_done,
    input  logic [ADDR_W-1:0]  gpu_addr,
    input  logic               gpu_wen,
    input  logic [COLOR_W-1:0] gpu_dout,
    output logic [ADDR_W:0]    fb_addr,
    output logic               fb_wen,
    output logic [COLOR_W-1:0] fb_dout,
    output logic               display_bank,
    output logic               busy,
    output logic [15:0]        frame_count,
    output logic [7:0]         overrun_count
);

    localparam int PIXELS = H_RES * V_RES;
    localparam logic [ADDR_W:0]   PIX_LIM = (ADDR_W + 1)'(PIXELS);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(PIXELS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        START,
        RENDER,
        WAIT_SWAP
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  clr_addr;
    logic [COLOR_W-1:0] color_q;
    logic               done_q;
    logic               done_rise;
    logic               swap;
    logic               overrun;
    logic               load;
    logic               in_range;

    assign done_rise = gpu_done && !done_q;
    assign in_range  = {1'b0, gpu_addr} < PIX_LIM;

    // A finished frame swaps on vsync, including the vsync that lands on the done edge.
    assign swap = vsync && ((state == WAIT_SWAP) ||
                            (state == RENDER && done_rise));

    // A vsync that finds the frame still being built is counted, never acted on.
    assign overrun = vsync && ((state == CLEAR) || (state == START) ||
                               (state == RENDER && !done_rise));

    // Start a fresh clear from idle, or straight after a swap while still enabled.
    assign load = (state == IDLE && enable && vsync) || (swap && enable);

    assign gpu_start = (state == START);
    assign busy      = (state != IDLE);

    // Frame sequencing, clear address walk and done-edge history.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            clr_addr <= '0;
            color_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= gpu_done;
            if (load) begin
                clr_addr <= '0;
                color_q  <= bg_color;
            end else if (state == CLEAR) begin
                clr_addr <= clr_addr + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (enable && vsync) state <= CLEAR;
                end
                CLEAR: begin
                    if (clr_addr == LAST) state <= START;
                end
                START: begin
                    state <= RENDER;
                end
                RENDER: begin
                    if (swap) state <= enable ? CLEAR : IDLE;
                    else if (done_rise) state <= WAIT_SWAP;
                end
                WAIT_SWAP: begin
                    if (swap) state <= enable ? CLEAR : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bank flip, completed-frame count and saturating overrun count.
    always_ff @(posedge clk) begin
        if (reset) begin
            display_bank  <= 1'b0;
            frame_count   <= '0;
            overrun_count <= '0;
        end else begin
            if (swap) begin
                display_bank <= ~display_bank;
                frame_count  <= frame_count + 16'd1;
            end
            if (overrun && overrun_count != 8'hFF) begin
                overrun_count <= overrun_count + 8'd1;
            end
        end
    end

    // Write port: clear pattern, or zero-latency gpu passthrough into the back bank.
    always_comb begin
        fb_wen  = 1'b0;
        fb_addr = '0;
        fb_dout = '0;
        if (state == CLEAR) begin
            fb_wen  = 1'b1;
            fb_addr = {~display_bank, clr_addr};
            fb_dout = color_q;
        end else if (state == RENDER) begin
            fb_wen  = gpu_wen && in_range;
            fb_addr = {~display_bank, gpu_addr};
            fb_dout = gpu_dout;
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed scenarios plus random traffic, checked every
// cycle against a phase-level reference model of the frame sequencer.
module tb_frame_sequencer;

    localparam int H   = 8;
    localparam int V   = 4;
    localparam int AW  = 6;
    localparam int CW  = 6;
    localparam int PIX = H * V;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          vsync;
    logic [CW-1:0] bg_color;
    logic          gpu_start;
    logic          gpu_done;
    logic [AW-1:0] gpu_addr;
    logic          gpu_wen;
    logic [CW-1:0] gpu_dout;
    logic [AW:0]   fb_addr;
    logic          fb_wen;
    logic [CW-1:0] fb_dout;
    logic          display_bank;
    logic          busy;
    logic [15:0]   frame_count;
    logic [7:0]    overrun_count;

    always #5 clk = ~clk;

    frame_sequencer #(
        .H_RES  (H),
        .V_RES  (V),
        .ADDR_W (AW),
        .COLOR_W(CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .vsync        (vsync),
        .bg_color     (bg_color),
        .gpu_start    (gpu_start),
        .gpu_done     (gpu_done),
        .gpu_addr     (gpu_addr),
        .gpu_wen      (gpu_wen),
        .gpu_dout     (gpu_dout),
        .fb_addr      (fb_addr),
        .fb_wen       (fb_wen),
        .fb_dout      (fb_dout),
        .display_bank (display_bank),
        .busy         (busy),
        .frame_count  (frame_count),
        .overrun_count(overrun_count)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: phase 0 idle, 1 clearing, 2 start, 3 rendering, 4 waiting for vsync.
    int m_ph   = 0;
    int m_idx  = 0;
    int m_col  = 0;
    int m_bank = 0;
    int m_frm  = 0;
    int m_ovr  = 0;
    int m_prev = 0;

    task automatic m_swap();
        m_bank = 1 - m_bank;
        m_frm  = (m_frm + 1) % 65536;
        if (enable) begin
            m_ph  = 1;
            m_idx = 0;
            m_col = int'(bg_color);
        end else begin
            m_ph = 0;
        end
    endtask

    task automatic m_over();
        if (m_ovr < 255) m_ovr++;
    endtask

    always @(posedge clk) begin
        int rise;
        if (reset) begin
            m_ph = 0; m_idx = 0; m_col = 0;
            m_bank = 0; m_frm = 0; m_ovr = 0; m_prev = 0;
        end else begin
            rise = (gpu_done && m_prev == 0) ? 1 : 0;
            if (m_ph == 0) begin
                if (enable && vsync) begin
                    m_ph = 1; m_idx = 0; m_col = int'(bg_color);
                end
            end else if (m_ph == 1) begin
                if (vsync) m_over();
                m_idx++;
                if (m_idx == PIX) m_ph = 2;
            end else if (m_ph == 2) begin
                if (vsync) m_over();
                m_ph = 3;
            end else if (m_ph == 3) begin
                if (rise == 1 && vsync) m_swap();
                else if (rise == 1) m_ph = 4;
                else if (vsync) m_over();
            end else begin
                if (vsync) m_swap();
            end
            m_prev = gpu_done ? 1 : 0;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        int ew;
        int back;
        back = 1 - m_bank;
        ew = (m_ph == 1 || (m_ph == 3 && gpu_wen && int'(gpu_addr) < PIX)) ? 1 : 0;
        check("fb_wen", 32'(fb_wen), 32'(ew));
        check("gpu_start", 32'(gpu_start), 32'(m_ph == 2));
        check("busy", 32'(busy), 32'(m_ph != 0));
        check("display_bank", 32'(display_bank), 32'(m_bank));
        check("frame_count", 32'(frame_count), 32'(m_frm));
        check("overrun_count", 32'(overrun_count), 32'(m_ovr));
        if (ew == 1 && m_ph == 1) begin
            check("clr_addr", 32'(fb_addr), 32'(back * (1 << AW) + m_idx));
            check("clr_dout", 32'(fb_dout), 32'(m_col));
        end
        if (ew == 1 && m_ph == 3) begin
            check("gpu_addr", 32'(fb_addr), 32'(back * (1 << AW) + int'(gpu_addr)));
            check("gpu_dout", 32'(fb_dout), 32'(gpu_dout));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int wen_cnt;
    int first_addr;
    int last_addr;
    int last_dout;

    task automatic wait_start();
        bit found;
        found = 0;
        wen_cnt = 0;
        first_addr = -1;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (fb_wen) begin
                if (wen_cnt == 0) first_addr = int'(fb_addr);
                last_addr = int'(fb_addr);
                last_dout = int'(fb_dout);
                wen_cnt++;
            end
            if (gpu_start) found = 1;
        end
        if (!found) check("start_timeout", 0, 1);
    endtask

    initial begin
        reset = 1; enable = 0; vsync = 0; bg_color = '0;
        gpu_done = 0; gpu_addr = '0; gpu_wen = 0; gpu_dout = '0;
        tick(); vsync = 1;
        tick(); vsync = 0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_bank", 32'(display_bank), 0);
        check("rst_frames", 32'(frame_count), 0);
        check("rst_wen", 32'(fb_wen), 0);
        tick(); reset = 0; gpu_wen = 1; gpu_addr = 6'd3;
        @(negedge clk);
        check("idle_gpu_drop", 32'(fb_wen), 0);

        tick(); gpu_wen = 0; enable = 1; bg_color = 6'b000011; vsync = 1;
        tick(); vsync = 0;
        wait_start();
        check("clear_count", 32'(wen_cnt), 32);
        check("clear_first", 32'(first_addr), 64);
        check("clear_last", 32'(last_addr), 95);
        check("clear_color", 32'(last_dout), 3);
        tick();
        @(negedge clk);
        check("start_one_cycle", 32'(gpu_start), 0);

        gpu_wen = 1; gpu_addr = 6'd5; gpu_dout = 6'b110000;
        #1;
        check("pass_wen", 32'(fb_wen), 1);
        check("pass_addr", 32'(fb_addr), 69);
        check("pass_dout", 32'(fb_dout), 48);
        tick(); gpu_addr = 6'd40;
        @(negedge clk);
        check("oob_drop", 32'(fb_wen), 0);
        tick(); gpu_wen = 0;

        vsync = 1; tick(); vsync = 0; tick();
        vsync = 1; tick(); vsync = 0;
        @(negedge clk);
        check("overrun_two", 32'(overrun_count), 2);
        check("overrun_noswap", 32'(display_bank), 0);

        tick(); gpu_done = 1;
        repeat (10) tick();
        vsync = 1; tick(); vsync = 0;
        @(negedge clk);
        check("swap_bank", 32'(display_bank), 1);
        check("swap_frames", 32'(frame_count), 1);
        check("swap_clear_addr", 32'(fb_addr), 0);
        tick(); gpu_done = 0;
        wait_start();
        tick(); gpu_done = 1; vsync = 1;
        tick(); vsync = 0;
        @(negedge clk);
        check("coin_frames", 32'(frame_count), 2);
        check("coin_overrun", 32'(overrun_count), 2);
        check("coin_clear_addr", 32'(fb_addr), 64);

        tick(); gpu_done = 0; enable = 0;
        wait_start();
        tick(); gpu_done = 1;
        repeat (3) tick();
        vsync = 1; tick(); vsync = 0;
        @(negedge clk);
        check("disable_busy", 32'(busy), 0);
        check("disable_frames", 32'(frame_count), 3);

        tick(); gpu_done = 0; enable = 1; vsync = 1;
        tick(); vsync = 0;
        wait_start();
        tick(); reset = 1;
        tick(); reset = 0;
        @(negedge clk);
        check("midrst_bank", 32'(display_bank), 0);
        check("midrst_frames", 32'(frame_count), 0);
        check("midrst_busy", 32'(busy), 0);

        tick(); vsync = 1;
        tick(); vsync = 0;
        wait_start();
        tick(); vsync = 1;
        repeat (260) tick();
        vsync = 0;
        @(negedge clk);
        check("overrun_sat", 32'(overrun_count), 255);
        tick(); reset = 1;
        tick(); reset = 0;

        repeat (4000) begin
            tick();
            reset    = ($urandom_range(0, 1499) == 0);
            enable   = ($urandom_range(0, 9) != 0);
            vsync    = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 19) == 0) gpu_done = ~gpu_done;
            gpu_wen  = $urandom_range(0, 1) == 1;
            gpu_addr = AW'($urandom_range(0, 63));
            gpu_dout = CW'($urandom);
            bg_color = CW'($urandom);
        end
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
